// File: rtl/bcd_conv_sched.sv
// bcd_conv_sched: two-requester arbitrated 8-bit binary to 3-digit BCD
// converter using a sequential double-dabble datapath (8 shift cycles).
// Optional feature macro: NEG_INPUT_EN. When it is defined, inputs are
// two's complement: the magnitude is converted and out_neg carries the
// captured sign. When it is undefined, inputs are unsigned and out_neg is 0.
module bcd_conv_sched #(
  parameter int unsigned PRIO_FIXED = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_a,
  input  logic [7:0] val_a,
  input  logic       req_b,
  input  logic [7:0] val_b,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       busy,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic [3:0] hundreds,
  output logic       out_neg,
  output logic       out_src,
  output logic       out_valid
);

  localparam int unsigned DW   = 8;
  localparam int unsigned BCDW = 12;
  localparam int unsigned SRW  = DW + BCDW;
  localparam int unsigned CW   = 3;

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_e;

  state_e          state_q, state_d;
  logic [SRW-1:0]  sr_q;
  logic [CW-1:0]   cnt_q;
  logic            src_q;
  logic            last_q;      // 0 = A granted last, 1 = B granted last
  logic [BCDW-1:0] dig_q;
  logic            src_out_q;
  logic            valid_q;
  logic            accept_c;
  logic            last_iter_c;
  logic [DW-1:0]   sel_val_c;
  logic [DW-1:0]   mag_c;
  logic [SRW-1:0]  sr_step_c;

  // One double-dabble iteration: adjust each BCD nibble >= 5, then shift.
  function automatic logic [SRW-1:0] dd_step(input logic [SRW-1:0] s);
    logic [SRW-1:0] a;
    a = s;
    for (int i = 0; i < 3; i++) begin
      if (a[DW+4*i +: 4] >= 4'd5) a[DW+4*i +: 4] = a[DW+4*i +: 4] + 4'd3;
    end
    return {a[SRW-2:0], 1'b0};
  endfunction

  assign accept_c    = gnt_a | gnt_b;
  assign last_iter_c = (state_q == SHIFT) && (cnt_q == CW'(7));
  assign sel_val_c   = gnt_b ? val_b : val_a;
  assign sr_step_c   = dd_step(sr_q);
  assign busy        = (state_q != IDLE);

`ifdef NEG_INPUT_EN
  logic neg_q;
  logic neg_out_q;
  assign mag_c   = sel_val_c[DW-1] ? DW'(-sel_val_c) : sel_val_c;
  assign out_neg = neg_out_q;
`else
  assign mag_c   = sel_val_c;
  assign out_neg = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = SHIFT;
      SHIFT:   if (cnt_q == CW'(7)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant outputs: only in IDLE; fixed priority or alternate on a tie.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (state_q == IDLE) begin
      gnt_a = req_a && (!req_b || (PRIO_FIXED != 0) || last_q);
      gnt_b = req_b && !(req_a && (!req_b || (PRIO_FIXED != 0) || last_q));
    end
  end

  // Conversion datapath: load on acceptance, iterate while shifting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      src_q  <= 1'b0;
      last_q <= 1'b1;
    end else if (accept_c) begin
      sr_q   <= {BCDW'(0), mag_c};
      cnt_q  <= '0;
      src_q  <= gnt_b;
      last_q <= gnt_b;
    end else if (state_q == SHIFT) begin
      sr_q  <= sr_step_c;
      cnt_q <= cnt_q + CW'(1);
    end
  end

`ifdef NEG_INPUT_EN
  // Sign capture at acceptance and publication with the digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q     <= 1'b0;
      neg_out_q <= 1'b0;
    end else begin
      if (accept_c)    neg_q     <= sel_val_c[DW-1];
      if (last_iter_c) neg_out_q <= neg_q;
    end
  end
`endif

  // Result registers: update on the final iteration, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dig_q     <= '0;
      src_out_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= last_iter_c;
      if (last_iter_c) begin
        dig_q     <= sr_step_c[SRW-1:DW];
        src_out_q <= src_q;
      end
    end
  end

  assign hundreds  = dig_q[11:8];
  assign tens      = dig_q[7:4];
  assign ones      = dig_q[3:0];
  assign out_src   = src_out_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Scoreboard bench for bcd_conv_sched: round-robin instance under directed
// and random traffic, plus a fixed-priority instance under a held tie.
module tb_bcd_conv_sched;

  typedef struct {
    logic        src;
    logic [12:0] r;      // {neg, hundreds, tens, ones}
    int          vcyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       req_a = 0, req_b = 0;
  logic [7:0] val_a = 0, val_b = 0;
  logic       gnt_a, gnt_b, busy, out_neg, out_src, out_valid;
  logic [3:0] ones, tens, hundreds;

  logic       req_a2 = 0, req_b2 = 0;
  logic [7:0] val_a2 = 0, val_b2 = 0;
  logic       gnt_a2, gnt_b2, busy2, out_neg2, out_src2, out_valid2;
  logic [3:0] ones2, tens2, hundreds2;

  bcd_conv_sched #(.PRIO_FIXED(0)) u_rr (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .val_a(val_a), .req_b(req_b),
    .val_b(val_b), .gnt_a(gnt_a), .gnt_b(gnt_b), .busy(busy), .ones(ones),
    .tens(tens), .hundreds(hundreds), .out_neg(out_neg), .out_src(out_src),
    .out_valid(out_valid));

  bcd_conv_sched #(.PRIO_FIXED(1)) u_fix (
    .clk(clk), .rst_n(rst_n), .req_a(req_a2), .val_a(val_a2), .req_b(req_b2),
    .val_b(val_b2), .gnt_a(gnt_a2), .gnt_b(gnt_b2), .busy(busy2), .ones(ones2),
    .tens(tens2), .hundreds(hundreds2), .out_neg(out_neg2), .out_src(out_src2),
    .out_valid(out_valid2));

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  exp_t        exp_q[$];
  logic [12:0] hold_r = '0;
  logic        m_last = 1'b1;   // model last-grant: 1 = B
  logic        pend = 1'b0;
  int          last_acc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference conversion from plain decimal arithmetic.
  function automatic logic [12:0] ref_conv(input logic [7:0] v);
    int   m;
    logic n;
    n = 1'b0;
    m = int'(v);
`ifdef NEG_INPUT_EN
    if (v[7]) begin
      n = 1'b1;
      m = 256 - int'(v);
    end
`endif
    return {n, 4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  // Monitor: pops the scoreboard on every out_valid, checks hold otherwise.
  always @(negedge clk) begin
    if (rst_n) begin
      exp_t e;
      chk("gnt_mutex", int'(gnt_a && gnt_b), 0);
      chk("gnt_mutex_fix", int'(gnt_a2 && gnt_b2), 0);
      if (out_valid) begin
        chk("hundreds_le2", int'(hundreds <= 4'd2), 1);
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("valid_cycle", cyc, e.vcyc);
          chk("out_src", int'(out_src), int'(e.src));
          chk("out_neg", int'(out_neg), int'(e.r[12]));
          chk("hundreds", int'(hundreds), int'(e.r[11:8]));
          chk("tens", int'(tens), int'(e.r[7:4]));
          chk("ones", int'(ones), int'(e.r[3:0]));
          hold_r = e.r;
        end
      end else begin
        chk("digits_hold", int'({out_neg, hundreds, tens, ones}), int'(hold_r));
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    req_a = 0; req_b = 0; req_a2 = 0; req_b2 = 0;
    exp_q.delete();
    hold_r = '0;
    m_last = 1'b1;
    pend = 1'b0;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_digits", int'({hundreds, tens, ones}), 0);
    chk("rst_src", int'(out_src), 0);
    chk("rst_neg", int'(out_neg), 0);
    chk("rst_gnt", int'({gnt_a, gnt_b}), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Serves all currently held requests, predicting each winner from the model.
  task automatic serve();
    logic wa, ga;
    int   t;
    pend = 1'b0;
    while (req_a || req_b) begin
      wa = (req_a && req_b) ? m_last : req_a;
      t = 0;
      @(negedge clk);
      while (!(gnt_a || gnt_b) && t < 40) begin
        t++;
        @(negedge clk);
      end
      if (t >= 40) begin
        chk("grant_timeout", 0, 1);
        req_a = 0; req_b = 0;
        break;
      end
      ga = gnt_a;
      chk("gnt_a", int'(gnt_a), int'(wa));
      chk("gnt_b", int'(gnt_b), int'(!wa));
      if (pend) chk("b2b_accept_spacing", cyc + 1 - last_acc, 10);
      last_acc = cyc + 1;
      pend = req_a && req_b;
      exp_q.push_back('{src: !wa, r: ref_conv(wa ? val_a : val_b), vcyc: cyc + 9});
      m_last = !wa;
      @(posedge clk); #1;
      if (ga) req_a = 0; else req_b = 0;
      @(negedge clk);
      chk("busy_after_accept", int'(busy), 1);
      chk("gnt_low_busy", int'({gnt_a, gnt_b}), 0);
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 40) begin
      t++;
      @(negedge clk);
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int nv;
    do_reset();

    // A alone with zero.
    @(posedge clk); #1;
    req_a = 1; val_a = 8'd0;
    serve();
    drain();

    // B alone with 250.
    @(posedge clk); #1;
    req_b = 1; val_b = 8'd250;
    serve();
    drain();

    // Simultaneous requests: A wins first tie, B follows 10 cycles later.
    @(posedge clk); #1;
    req_a = 1; val_a = 8'd10; req_b = 1; val_b = 8'd137;
    serve();
    drain();

    // Request raised and dropped while busy must be ignored.
    @(posedge clk); #1;
    req_a = 1; val_a = 8'd77;
    serve();
    req_b = 1; val_b = 8'd99;
    repeat (3) @(posedge clk);
    #1 req_b = 0;
    drain();
    repeat (15) @(posedge clk);

    // Reset four cycles into a 255 conversion aborts it.
    #1 req_a = 1; val_a = 8'd255;
    serve();
    repeat (3) @(posedge clk);
    do_reset();
    repeat (15) @(posedge clk);
    #1 req_a = 1; val_a = 8'd255;
    serve();
    drain();

    // Two's complement corner values (meaningful in the signed build).
    @(posedge clk); #1;
    req_a = 1; val_a = 8'h89;
    serve();
    @(posedge clk); #1;
    req_a = 1; val_a = 8'h80;
    serve();
    drain();

    // Randomized traffic: A only, B only, or both.
    for (int i = 0; i < 40; i++) begin
      int sel;
      sel = int'($urandom_range(0, 2));
      @(posedge clk); #1;
      val_a = 8'($urandom);
      val_b = 8'($urandom);
      req_a = (sel != 1);
      req_b = (sel != 0);
      serve();
      if ($urandom_range(0, 3) == 0) drain();
    end
    drain();

    // Fixed-priority instance: both held, only A is ever served.
    @(posedge clk); #1;
    val_a2 = 8'($urandom);
    val_b2 = 8'($urandom);
    req_a2 = 1; req_b2 = 1;
    nv = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      chk("fix_no_gnt_b", int'(gnt_b2), 0);
      if (out_valid2) begin
        nv++;
        chk("fix_src", int'(out_src2), 0);
        chk("fix_digits", int'({out_neg2, hundreds2, tens2, ones2}), int'(ref_conv(val_a2)));
      end
    end
    chk("fix_valid_count", nv, 4);
    req_a2 = 0; req_b2 = 0;

    repeat (12) @(posedge clk);
    chk("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
